// File: rtl/sram_controller.sv
// Word-wide MEM-stage responder for a 16-bit asynchronous SRAM.
// Each 32-bit access runs as a low-halfword phase and then a high-halfword phase.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_e;

    localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [16:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_op_q, rd_op_d;
    logic [31:0] rdata_q, rdata_d;
    logic [17:0] addr_q, addr_d;

    logic [31:0] offs;
    logic [16:0] idx_in;
    logic        phase;
    logic        dq_drv;
    logic [15:0] dq_out;
    logic        unused_bits;

    assign offs        = address - BASE_ADDR;
    assign idx_in      = offs[18:2];
    assign unused_bits = ^{offs[31:19], offs[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= 17'd0;
            wdata_q <= 32'd0;
            rd_op_q <= 1'b1;
            rdata_q <= 32'd0;
            addr_q  <= 18'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_op_q <= rd_op_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_op_d = rd_op_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd_en || wr_en) begin
                    idx_d   = idx_in;
                    wdata_d = write_data;
                    rd_op_d = rd_en;
                    addr_d  = {idx_in, 1'b0};
                    cnt_d   = 3'd0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_q == LAST) begin
                    if (rd_op_q) begin
                        rdata_d[15:0] = SRAM_DQ;
                    end
                    addr_d  = {idx_q, 1'b1};
                    cnt_d   = 3'd0;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HIGH: begin
                if (cnt_q == LAST) begin
                    if (rd_op_q) begin
                        rdata_d[31:16] = SRAM_DQ;
                    end
                    cnt_d   = 3'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controls are decoded from registered state only, so a reset edge
    // releases WE_N and the bus in the same cycle it returns to IDLE.
    assign phase  = (state_q == S_LOW) || (state_q == S_HIGH);
    assign dq_drv = phase && !rd_op_q;
    assign dq_out = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];

    assign SRAM_DQ   = dq_drv ? dq_out : 16'hzzzz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = !phase;
    assign SRAM_UB_N = !phase;
    assign SRAM_LB_N = !phase;
    assign SRAM_OE_N = !(phase && rd_op_q);
    assign SRAM_WE_N = !(phase && !rd_op_q);

    assign read_data = rdata_q;
    assign ready     = (state_q == S_DONE) ||
                       ((state_q == S_IDLE) && !rd_en && !wr_en);

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side responder for the pipeline's MEM stage. It services the word-wide mem_read/mem_write requests issued by the pipeline.
- It drives an external 16-bit asynchronous SRAM, splitting each 32-bit access into a low-halfword phase and a high-halfword phase.
- It deasserts ready while an access is in flight; the top level ORs ~ready into the pipeline freeze so that every pipeline register holds.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory word 0; subtracted from the incoming address.
- WAIT_CYCLES, 1: extra cycles per halfword phase (legal range 0..7). Phase length N = WAIT_CYCLES+1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rd_en  in  1  word read request (from the EXE/MEM register).
- wr_en  in  1  word write request.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (val_Rm).
- read_data  out  32  loaded word (registered).
- ready  out  1  1 = no access in flight; 0 = pipeline must freeze.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low SRAM controls.

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, cycle counter=0, read_data=0.
  - SRAM_ADDR=0.
  - All SRAM_*_N=1.
  - SRAM_DQ=Z.
  - ready=1, provided rd_en and wr_en are low.
- Address map:
  - idx = ((address - BASE_ADDR) mod 2^32) >> 2; only idx[16:0] is used.
  - Low-half SRAM address = {idx[16:0],0}; high-half SRAM address = {idx[16:0],1}.
  - address[1:0] is ignored.
- ready is combinational:
  - 1 in DONE.
  - 1 in IDLE when rd_en=wr_en=0.
  - 0 otherwise, so a new request pulls ready low in the same cycle it appears.
- Acceptance: in IDLE with rd_en|wr_en=1, the block latches idx, write_data and op, then moves to LOW.
  - op=read if rd_en=1; rd_en has priority when both are high, and nothing is written in that case.
  - Inputs are not sampled again until the next acceptance. A request dropping mid-access has no effect; the access completes.
- State machine IDLE -> LOW -> HIGH -> DONE -> IDLE:
  - LOW and HIGH each last N cycles, counted by a 3-bit counter that is cleared on phase entry.
  - DONE lasts 1 cycle.
- In LOW and HIGH:
  - CE_N=0, UB_N=0, LB_N=0.
  - SRAM_ADDR = that phase's address.
  - Read: OE_N=0, WE_N=1, DQ=Z.
  - Write: OE_N=1, WE_N=0, DQ driven with write_data[15:0] in LOW and write_data[31:16] in HIGH.
- Read capture:
  - On the last cycle of LOW, SRAM_DQ is registered into read_data[15:0].
  - On the last cycle of HIGH, SRAM_DQ is registered into read_data[31:16].
  - read_data is stable from DONE until the next read's LOW capture. Writes never alter read_data.
- In IDLE and DONE: all SRAM_*_N=1 and DQ=Z. SRAM_ADDR holds its last value.
- Latency: the request appears in cycle 0 (IDLE). LOW occupies cycles 1..N, HIGH occupies N+1..2N, DONE is cycle 2N+1.
  - ready=0 for cycles 0..2N; the pipeline is stalled 2N+1 cycles per memory access.
  - Non-memory instructions (rd_en=wr_en=0) see ready=1 and add no stall.
- Back-to-back requests: a request present during DONE is not accepted there. It is accepted in the following IDLE cycle, so there is a minimum of one IDLE cycle between accesses.
- rst asserted mid-access (any state) returns the block to IDLE at the next edge. WE_N=1 and DQ=Z from that edge on. read_data=0; any partial capture is discarded.
- The block never drives DQ during a read phase. DQ changes only while WE_N is held low for a whole phase, so no bus contention occurs.

Test Plan:
1. Reset:
   - Stimulus: rst=1 for 2 cycles, rd_en=wr_en=0.
   - Response: ready=1, read_data=0, all SRAM_*_N=1, DQ=Z, SRAM_ADDR=0.
2. Write (WAIT_CYCLES=1):
   - Stimulus: wr_en=1, address=1032, write_data=0xDEADBEEF.
   - Response: ready=0 for 5 cycles, then 1 in DONE.
   - SRAM model holds [4]=0xBEEF and [5]=0xDEAD.
   - WE_N is low for exactly 2 cycles per phase.
3. Read-back:
   - Stimulus: rd_en=1, address=1032 after test 2.
   - Response: read_data=0xDEADBEEF in DONE (cycle 5); OE_N low for 4 cycles; DQ never driven by the DUT.
4. Both enables and address alignment:
   - Stimulus: rd_en=wr_en=1, address=1035.
   - Response: performs a read of idx 2 (SRAM addresses 4/5); SRAM contents unchanged; read_data=0xDEADBEEF.
5. Mid-access reset:
   - Stimulus: a write to address=1024 with data 0x12345678; rst pulsed in HIGH cycle 1.
   - Response: IDLE the next cycle, ready=1, WE_N=1, DQ=Z. The following rd_en read of 1024 is accepted one cycle later.
6. Back-to-back and WAIT_CYCLES=0:
   - Stimulus: two consecutive reads of different words, with rd_en held.
   - Response: each shows ready low for 3 cycles; one IDLE cycle separates DONE from the next LOW; read_data matches each word in turn.
